cs_feeder: RTL and testbench
============================

# cs_feeder

Streaming sample source that drives the 8-bit `X` input of the CS smoothing filter from a bursty upstream producer. It buffers samples in a FIFO and presents exactly one new sample on `X` per clock while streaming. It also tracks window warm-up so that `y_valid` marks the cycles in which CS output `Y` reflects a full window of 9 fresh samples. It sits between the host/loader and CS, on the transmit side of the `X` interface.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `PRIME`, 4: FIFO level required before streaming starts or resumes; 1 ≤ PRIME ≤ DEPTH.
- `WINDOW`, 9: CS window length, in samples.
- `LAT`, 1: cycles from a sample appearing on `X` to its `Y` result being valid at CS; ≥ 1.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `in_data` in 8: upstream sample.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: FIFO can accept a sample. Push occurs when `in_valid && in_ready`.
- `start` in 1: one-cycle pulse; begins streaming and clears `underrun`.
- `stop` in 1: one-cycle pulse; returns the block to IDLE.
- `X` out 8: registered sample to CS.
- `y_valid` out 1: CS `Y` is meaningful this cycle.
- `underrun` out 1: sticky; FIFO went empty while streaming.
- `level` out log2(DEPTH)+1: current FIFO occupancy.

## Operation
- FIFO: circular buffer with read/write pointers that wrap at DEPTH, plus an occupancy counter.
  - `in_ready = (level != DEPTH)`. A push when full is not possible, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave `level` unchanged.
  - A pushed entry is poppable on the next cycle. There is no bypass path.
- States:
  - IDLE: no pops; `X` holds its last value; `y_valid` = 0. Pushes are allowed.
    - `start` → FILL.
  - FILL: no pops.
    - When `level >= PRIME` → STREAM.
    - `stop` → IDLE.
  - STREAM: one pop per cycle; the popped value is registered into `X`; `warm` increments, saturating at WINDOW.
    - FIFO empty at a pop attempt: no pop, `X` holds, `underrun` ← 1, `warm` ← 0 → FILL.
    - `stop` → IDLE and `warm` ← 0. When `stop` and the empty condition coincide, `stop` wins.
- `start` received in FILL or STREAM clears `underrun` and `warm`, then re-enters FILL.
- `warm` counts fresh samples emitted since the last (re)start, underrun, or stop.
- `y_valid` = (`warm == WINDOW`), delayed LAT cycles through a shift register. The shift register clears on entry to IDLE or FILL.

## Timing
- Reset values: `X` = 0x00, `y_valid` = 0, `underrun` = 0, `in_ready` = 1, `level` = 0, state = IDLE, `warm` = 0, pointers = 0.
- A sample popped at posedge k is on `X` from k+ and is sampled by CS at posedge k+1.
- Latency:
  - Push at edge p in STREAM with a non-empty FIFO: the sample appears on `X` no earlier than p+1.
  - `start` at edge s with `level >= PRIME` already: FILL at s, STREAM at s+1, first pop at edge s+2.
- `y_valid` first rises LAT cycles after the edge that brings `warm` to WINDOW, i.e. after the 9th fresh sample is on `X`.
- `y_valid` drops in the cycle after an underrun or stop edge. A new valid stream then needs 9 fresh samples plus LAT.
- Reset asserted mid-stream: all outputs return to reset values asynchronously. FIFO contents are discarded (`level` = 0).
- All outputs are registered. There are no combinational paths from inputs to outputs, except `in_ready`, which derives from registered `level` only.

## Test plan
- Reset: drive `reset` low mid-STREAM with `level` = 7. Required: `X` = 00, `level` = 0, `y_valid` = 0, `in_ready` = 1 immediately, with no clock edge.
- Basic stream:
  - Stimulus: push 0x10..0x1F continuously, pulse `start`.
  - Required: `X` steps 0x10, 0x11, … one per cycle; `y_valid` rises LAT cycles after `X` = 0x18 and stays high.
  - Compare `Y` against the CS golden model.
- Full:
  - Stimulus: in IDLE, push 17 samples back-to-back.
  - Required: `in_ready` = 0 after the 16th push; the 17th is held; `level` = 16.
  - After `start`, `in_ready` returns to 1 on the first pop cycle.
- Underrun:
  - Stimulus: start with PRIME samples, then stop pushing.
  - Required: `underrun` = 1 after the FIFO empties; `X` holds the last value; `y_valid` = 0.
  - After 4 more pushes, streaming resumes and `y_valid` stays 0 until 9 new samples plus LAT.
- Stop vs empty in the same cycle: assert `stop` on the cycle the FIFO empties. Required: state IDLE, `underrun` stays 0.
- Pointer wrap: stream 100 samples 0x00..0x63 with random `in_valid` gaps that never starve the FIFO. Required: `X` sequence exactly 0x00..0x63 in order and `underrun` = 0.

Source files
------------

// File: rtl/cs_feeder.sv
// Sample feeder for the CS smoothing filter: buffers bursty upstream data and streams one sample per clock on X.
// Tracks window warm-up so y_valid marks cycles where CS output reflects a full window of fresh samples.
//   state  | meaning
//   IDLE   | no pops, X holds, pushes still accepted
//   FILL   | waiting for level >= PRIME before streaming
//   STREAM | one pop per clock into X; empty FIFO flags underrun
module cs_feeder #(
  parameter int DEPTH  = 16,
  parameter int PRIME  = 4,
  parameter int WINDOW = 9,
  parameter int LAT    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     stop,
  output logic [7:0]               X,
  output logic                     y_valid,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      x_q, x_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic            und_q, und_d;
  logic [LAT-1:0]  yv_q, yv_d;
  logic            push, pop;

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    warm_d  = warm_q;
    und_d   = und_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          und_d   = 1'b0;
          warm_d  = '0;
        end
      end
      S_FILL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          und_d  = 1'b0;
          warm_d = '0;
        end else if (level_q >= LW'(PRIME)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // stop takes priority over the empty-FIFO underrun condition
        if (stop) begin
          state_d = S_IDLE;
          warm_d  = '0;
        end else if (start) begin
          state_d = S_FILL;
          und_d   = 1'b0;
          warm_d  = '0;
        end else if (level_q == '0) begin
          state_d = S_FILL;
          und_d   = 1'b1;
          warm_d  = '0;
        end else begin
          pop = 1'b1;
          x_d = mem_q[rd_ptr_q];
          if (warm_q != WW'(WINDOW)) warm_d = warm_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (state_d != S_STREAM) yv_d = '0;
    else                     yv_d = (yv_q << 1) | LAT'(warm_q == WW'(WINDOW));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      x_q      <= '0;
      warm_q   <= '0;
      und_q    <= 1'b0;
      yv_q     <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      x_q     <= x_d;
      warm_q  <= warm_d;
      und_q   <= und_d;
      yv_q    <= yv_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign X        = x_q;
  assign y_valid  = yv_q[LAT-1];
  assign underrun = und_q;
  assign level    = level_q;

endmodule

// File: tb/tb_cs_feeder.sv
// Bench for cs_feeder: randomized and directed stimulus checked each cycle against a queue-based reference model.
module tb_cs_feeder;
  localparam int DEPTH  = 16;
  localparam int PRIME  = 4;
  localparam int WINDOW = 9;
  localparam int LAT    = 1;
  localparam int MI = 0, MF = 1, MS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic       stop;
  logic [7:0] X;
  logic       y_valid;
  logic       underrun;
  logic [4:0] level;

  cs_feeder #(.DEPTH(DEPTH), .PRIME(PRIME), .WINDOW(WINDOW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .stop(stop), .X(X), .y_valid(y_valid), .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int           m_mode, m_warm, m_streak;
  bit           m_und, m_y, m_popped;
  logic [7:0]   m_x;
  byte unsigned m_q[$];
  int           m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MI; m_warm = 0; m_streak = 0; m_und = 0; m_y = 0; m_popped = 0; m_x = 8'h00;
    m_q.delete(); m_hist.delete();
  endtask

  // one clock edge of the reference behaviour, using pre-edge state
  task automatic model_edge(input bit v, input logic [7:0] d, input bit st, input bit sp);
    bit push;
    int pre_warm;
    push = v && (m_q.size() != DEPTH);
    pre_warm = m_warm;
    m_popped = 0;
    case (m_mode)
      MI: if (st) begin m_mode = MF; m_und = 0; m_warm = 0; end
      MF: begin
        if (sp) m_mode = MI;
        else if (st) begin m_und = 0; m_warm = 0; end
        else if (m_q.size() >= PRIME) m_mode = MS;
      end
      default: begin
        if (sp) begin m_mode = MI; m_warm = 0; end
        else if (st) begin m_mode = MF; m_und = 0; m_warm = 0; end
        else if (m_q.size() == 0) begin m_mode = MF; m_und = 1; m_warm = 0; end
        else begin
          m_x = m_q.pop_front();
          m_popped = 1;
          m_warm = (m_warm + 1 > WINDOW) ? WINDOW : m_warm + 1;
        end
      end
    endcase
    if (push) m_q.push_back(d);
    m_hist.push_front(pre_warm);
    if (m_hist.size() > LAT) void'(m_hist.pop_back());
    if (m_mode == MS) m_streak++; else m_streak = 0;
    m_y = (m_streak >= LAT) && (m_hist.size() >= LAT) && (m_hist[LAT-1] == WINDOW);
  endtask

  task automatic check_all();
    chk("x", X, m_x);
    chk("level", level, m_q.size());
    chk("in_ready", in_ready, m_q.size() != DEPTH);
    chk("underrun", underrun, m_und);
    chk("y_valid", y_valid, m_y);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit st, input bit sp, output bit acc);
    in_valid = v; in_data = d; start = st; stop = sp;
    acc = v && (m_q.size() != DEPTH);
    @(posedge clk);
    model_edge(v, d, st, sp);
    #1;
    check_all();
    in_valid = 0; start = 0; stop = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit acc;
    int cyc, t18, ty, n;
    logic [7:0] xr;
    logic [7:0] got[$];
    int idx;
    bit v;

    reset = 1'b0; in_valid = 0; in_data = 0; start = 0; stop = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // basic stream: 0x10..0x1F with start on the first push
    t18 = -1; ty = -1; cyc = 0; n = 0;
    for (int i = 0; i < 46; i++) begin
      if (i < 16) step(1'b1, 8'(8'h10 + i), i == 0, 1'b0, acc);
      else        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
      cyc++;
      if (m_popped) begin chk("basic_seq", X, 8'(8'h10 + n)); n++; end
      if (X == 8'h18 && t18 < 0) t18 = cyc;
      if (y_valid && ty < 0) ty = cyc;
      if (m_und) break;
    end
    chk("basic_count", n, 16);
    chk("yv_latency", ty - t18, LAT);
    chk("basic_underrun_end", underrun, 1);

    // full: 17 back-to-back pushes in IDLE
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
    chk("full_level", level, 16);
    chk("full_ready", in_ready, 0);
    chk("full_17th_held", acc, 0);
    step(1'b1, 8'h50, 1'b1, 1'b0, acc);
    chk("start_clears_und", underrun, 0);
    step(1'b1, 8'h50, 1'b0, 1'b0, acc);
    chk("ready_before_pop", in_ready, 0);
    step(1'b1, 8'h50, 1'b0, 1'b0, acc);
    chk("ready_after_pop", in_ready, 1);
    chk("first_pop_x", X, 8'h40);
    for (int i = 0; i < 4 && !acc; i++) step(1'b1, 8'h50, 1'b0, 1'b0, acc);
    chk("held_17th_pushed", acc, 1);

    // drain to level 7, then assert reset asynchronously
    for (int i = 0; i < 40 && !(m_mode == MS && m_q.size() == 7); i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("reach_level7", m_q.size(), 7);
    chk("pre_reset_level", level, 7);
    reset = 1'b0;
    #1;
    chk("rst_x", X, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // underrun then resume
    for (int i = 0; i < PRIME; i++) step(1'b1, 8'(8'h60 + i), i == 0, 1'b0, acc);
    for (int i = 0; i < 20 && !m_und; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("underrun_set", underrun, 1);
    chk("underrun_x_hold", X, 8'h63);
    chk("underrun_yv", y_valid, 0);
    xr = 8'h00;
    for (int i = 0; i < 24; i++) begin
      step(i < 14, 8'(8'h70 + i), 1'b0, 1'b0, acc);
      if (y_valid && xr == 8'h00) xr = X;
    end
    chk("resume_y_first_x", xr, 8'(8'h78 + LAT));

    // stop coinciding with empty FIFO
    do_reset();
    for (int i = 0; i < PRIME; i++) step(1'b1, 8'(8'h20 + i), i == 0, 1'b0, acc);
    for (int i = 0; i < 20 && !(m_mode == MS && m_q.size() == 0); i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("stop_empty_mode_idle", m_mode, MI);
    chk("stop_empty_und", underrun, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("idle_no_und", underrun, 0);
    chk("idle_x_hold", X, 8'h23);

    // pointer wrap with random gaps that never starve the FIFO
    do_reset();
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    for (int i = 0; i < 600 && got.size() < 100; i++) begin
      v = (idx < 100) && (($urandom_range(0, 3) != 0) || (m_q.size() < 6));
      step(v, 8'(idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
      if (m_popped) got.push_back(X);
    end
    chk("wrap_count", got.size(), 100);
    chk("wrap_underrun", underrun, 0);
    for (int i = 0; i < got.size(); i++) chk("wrap_seq", got[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
